// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch core: segment codes, display
// blanking values, scan digit positions and adjust field selects.
package stopwatch_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 blank.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: edge-detected divided clocks, run/pause/adjust counting
// and a registered 4-digit multiplexed seven-segment drive.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clock1Hz,
    input  logic       clock2Hz,
    input  logic       clockFast,
    input  logic       clockBlink,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] min_o,
    output logic [5:0] sec_o,
    output logic       paused,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [5:0] MAX6 = 6'(MAX_VAL);

    logic       prev_1hz, prev_2hz, prev_fast;
    logic       tick_1hz, tick_2hz, tick_fast;
    logic [1:0] idx;
    logic [3:0] digit;
    logic [6:0] dec_seg;
    logic       blink;

    // Prev registers reset high so a source already high at release is not a tick
    assign tick_1hz  = clock1Hz  & ~prev_1hz;
    assign tick_2hz  = clock2Hz  & ~prev_2hz;
    assign tick_fast = clockFast & ~prev_fast;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v);
        return (v == MAX6) ? 6'd0 : v + 6'd1;
    endfunction

    // Compare-chain split of a 0..59 value into tens and ones
    function automatic logic [7:0] split_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        if (v >= 6'd50)      begin t = 4'd5; r = v - 6'd50; end
        else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
        else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
        else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
        else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
        else                 begin t = 4'd0; r = v;         end
        return {t, r[3:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_1hz  <= 1'b1;
            prev_2hz  <= 1'b1;
            prev_fast <= 1'b1;
            min_o     <= 6'd0;
            sec_o     <= 6'd0;
            paused    <= 1'b0;
            idx       <= DIG_SEC_ONES;
        end else begin
            prev_1hz  <= clock1Hz;
            prev_2hz  <= clock2Hz;
            prev_fast <= clockFast;
            if (pause_p)
                paused <= ~paused;
            // Count decisions use the pre-toggle paused value
            if (adj) begin
                if (tick_2hz) begin
                    if (sel == SEL_MIN) min_o <= wrap_inc(min_o);
                    else                sec_o <= wrap_inc(sec_o);
                end
            end else if (tick_1hz && !paused) begin
                if (sec_o == MAX6) begin
                    sec_o <= 6'd0;
                    min_o <= wrap_inc(min_o);
                end else begin
                    sec_o <= sec_o + 6'd1;
                end
            end
            if (tick_fast)
                idx <= idx + 2'd1;
        end
    end

    always_comb begin
        logic [7:0] s_bcd, m_bcd;
        s_bcd = split_bcd(sec_o);
        m_bcd = split_bcd(min_o);
        digit = s_bcd[3:0];
        case (idx)
            DIG_SEC_ONES: digit = s_bcd[3:0];
            DIG_SEC_TENS: digit = s_bcd[7:4];
            DIG_MIN_ONES: digit = m_bcd[3:0];
            DIG_MIN_TENS: digit = m_bcd[7:4];
            default:      digit = s_bcd[3:0];
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    assign blink = adj && clockBlink &&
                   ((sel == SEL_SEC && (idx == DIG_SEC_ONES || idx == DIG_SEC_TENS)) ||
                    (sel == SEL_MIN && (idx == DIG_MIN_ONES || idx == DIG_MIN_TENS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (blink) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dec_seg;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: reset, run wrap, pause, adjust, scan, blink.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst, clock1Hz, clock2Hz, clockFast, clockBlink;
    logic       pause_p, adj, sel;
    logic [5:0] min_o, sec_o;
    logic       paused;
    logic [3:0] an;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.MAX_VAL(59)) dut (
        .clk        (clk),
        .rst        (rst),
        .clock1Hz   (clock1Hz),
        .clock2Hz   (clock2Hz),
        .clockFast  (clockFast),
        .clockBlink (clockBlink),
        .pause_p    (pause_p),
        .adj        (adj),
        .sel        (sel),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .paused     (paused),
        .an         (an),
        .seg        (seg)
    );

    // Advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // High for two cycles to show one tick per rise regardless of high time
    task automatic rise_1hz();
        clock1Hz = 1'b1; step(2);
        clock1Hz = 1'b0; step(1);
    endtask

    task automatic rise_2hz(input int n);
        repeat (n) begin
            clock2Hz = 1'b1; step(2);
            clock2Hz = 1'b0; step(1);
        end
    endtask

    task automatic rise_fast();
        clockFast = 1'b1; step(1);
        clockFast = 1'b0; step(1);
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
        chk({tag, "_an"}, 32'(an), 32'(e_an));
        chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    initial begin
        rst = 1'b1; clock1Hz = 1'b1; clock2Hz = 1'b0; clockFast = 1'b0;
        clockBlink = 1'b0; pause_p = 1'b0; adj = 1'b0; sel = 1'b0;
        #1;
        step(2);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_min", 32'(min_o), 32'd0);
        chk("rst_sec", 32'(sec_o), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);

        // clock1Hz held high through release: no tick until seen low
        rst = 1'b0; step(3);
        chk("no_tick_high_at_release", 32'(sec_o), 32'd0);
        chk("idle_disp_an", 32'(an), 32'hE);
        chk("idle_disp_seg", 32'(seg), 32'h40);
        clock1Hz = 1'b0; step(1);
        clock1Hz = 1'b1; step(1);
        chk("first_tick_latency", 32'(sec_o), 32'd1);
        chk("seg_lags_count", 32'(seg), 32'h40);
        step(1);
        chk("seg_after_two", 32'(seg), 32'h79);
        clock1Hz = 1'b0; step(1);

        // Adjust minutes 0 -> 58, then 59, 0, 1 with seconds untouched
        adj = 1'b1; sel = 1'b0;
        rise_2hz(58);
        chk("adj_min58", 32'(min_o), 32'd58);
        rise_2hz(1); chk("adj_min59", 32'(min_o), 32'd59);
        rise_2hz(1); chk("adj_min_wrap0", 32'(min_o), 32'd0);
        rise_2hz(1); chk("adj_min1", 32'(min_o), 32'd1);
        chk("adj_sec_unchanged", 32'(sec_o), 32'd1);
        rise_1hz(); rise_1hz();
        chk("adj_ignores_1hz_sec", 32'(sec_o), 32'd1);
        chk("adj_ignores_1hz_min", 32'(min_o), 32'd1);

        // Preload 59:59 then run one tick
        rise_2hz(58);
        sel = 1'b1;
        rise_2hz(58);
        chk("pre_min59", 32'(min_o), 32'd59);
        chk("pre_sec59", 32'(sec_o), 32'd59);
        adj = 1'b0;
        rise_1hz();
        chk("wrap_min", 32'(min_o), 32'd0);
        chk("wrap_sec", 32'(sec_o), 32'd0);

        // 00:59 -> 01:00
        adj = 1'b1; sel = 1'b1;
        rise_2hz(59);
        chk("pre_sec59b", 32'(sec_o), 32'd59);
        adj = 1'b0;
        rise_1hz();
        chk("carry_min", 32'(min_o), 32'd1);
        chk("carry_sec", 32'(sec_o), 32'd0);

        // Set 00:05, then pause in the same cycle as a tick
        adj = 1'b1; sel = 1'b0;
        rise_2hz(59);
        sel = 1'b1;
        rise_2hz(5);
        adj = 1'b0;
        chk("pre_pause", 32'(sec_o), 32'd5);
        clock1Hz = 1'b1; pause_p = 1'b1; step(1);
        pause_p = 1'b0;
        chk("pause_tick_sec", 32'(sec_o), 32'd6);
        chk("pause_set", 32'(paused), 32'd1);
        clock1Hz = 1'b0; step(1);
        rise_1hz(); rise_1hz(); rise_1hz();
        chk("paused_hold", 32'(sec_o), 32'd6);
        pause_p = 1'b1; step(1); pause_p = 1'b0;
        chk("pause_clear", 32'(paused), 32'd0);
        rise_1hz();
        chk("resume_tick", 32'(sec_o), 32'd7);

        // Load 12:34 and walk the scan
        adj = 1'b1; sel = 1'b0;
        rise_2hz(12);
        sel = 1'b1;
        rise_2hz(27);
        adj = 1'b0; step(2);
        chk("scan_min12", 32'(min_o), 32'd12);
        chk("scan_sec34", 32'(sec_o), 32'd34);
        chk_disp("scan_d0", 4'hE, 7'h19);
        rise_fast(); chk_disp("scan_d1", 4'hD, 7'h30);
        rise_fast(); chk_disp("scan_d2", 4'hB, 7'h24);
        rise_fast(); chk_disp("scan_d3", 4'h7, 7'h79);
        rise_fast(); chk_disp("scan_wrap", 4'hE, 7'h19);

        // Blink seconds field
        adj = 1'b1; sel = 1'b1; clockBlink = 1'b1; step(1);
        chk_disp("blink_d0", 4'hF, 7'h7F);
        rise_fast(); chk_disp("blink_d1", 4'hF, 7'h7F);
        rise_fast(); chk_disp("blink_d2_visible", 4'hB, 7'h24);
        clockBlink = 1'b0; step(1);

        // Reset mid-operation
        pause_p = 1'b1; step(1); pause_p = 1'b0;
        rst = 1'b1; step(1);
        chk("midrst_min", 32'(min_o), 32'd0);
        chk("midrst_sec", 32'(sec_o), 32'd0);
        chk("midrst_paused", 32'(paused), 32'd0);
        chk_disp("midrst", 4'hF, 7'h7F);
        rst = 1'b0; adj = 1'b0; step(1);
        chk_disp("midrst_idx0", 4'hE, 7'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping and display core of the stopwatch. It consumes the four divided clocks from `masterCLK` (`clock1Hz`, `clock2Hz`, `clockFast`, `clockBlink`) as level inputs sampled on the system clock and converts them to single-cycle ticks. It maintains an MM:SS count with pause and per-field adjust modes. It drives the 4-digit multiplexed seven-segment display.

## Interface
- `MAX_VAL`, default 59: terminal value of both the minutes and seconds fields.
- `clk`  in  1  system clock; same domain that generates the `masterCLK` outputs.
- `rst`  in  1  synchronous, active-high reset.
- `clock1Hz`  in  1  count source; each rising edge is one count tick.
- `clock2Hz`  in  1  adjust source; each rising edge is one adjust tick.
- `clockFast`  in  1  display scan source; each rising edge advances the digit.
- `clockBlink`  in  1  blink phase level; 1 = blank phase.
- `pause_p`  in  1  debounced single-cycle pulse; toggles `paused`.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  adjust field select; 0 = minutes, 1 = seconds.
- `min_o`  out  6  minutes value, 0..MAX_VAL.
- `sec_o`  out  6  seconds value, 0..MAX_VAL.
- `paused`  out  1  pause state.
- `an`  out  4  digit anodes, active low; bit 0 = rightmost digit.
- `seg`  out  7  cathodes, active low, order {g,f,e,d,c,b,a}.

## Operation
- **Edge detect.** Each of `clock1Hz`, `clock2Hz` and `clockFast` has a prev register. The tick is `rise = in & ~prev`. The prev registers reset to 1, so an input that is already high at reset release produces no tick until it has been seen low.
- **Pause.** `pause_p` toggles `paused` in any mode.
- **Run mode** (`adj=0`, `paused=0`), on a 1 Hz tick:
  - `sec_o` increments.
  - When `sec_o==MAX_VAL`, `sec_o` goes to 0 and `min_o` increments.
  - 59:59 wraps to 00:00.
- **Paused** (`adj=0`, `paused=1`): 1 Hz ticks are ignored and the count holds.
- **Adjust mode** (`adj=1`):
  - 1 Hz ticks are ignored.
  - On a 2 Hz tick, the field chosen by `sel` increments by 1, wrapping from MAX_VAL to 0. There is no carry into the other field.
  - Adjust operates regardless of `paused`.
- **Simultaneous events.**
  - Tick together with `pause_p`: the tick is evaluated against the old `paused` value.
  - `adj`, `sel` and `pause_p` are all sampled in the tick cycle.
  - `rst` overrides everything.
- **Scan.** A 2-bit `idx` advances 0→1→2→3→0 on each `clockFast` tick. Digit mapping:
  - 0 = seconds ones
  - 1 = seconds tens
  - 2 = minutes ones
  - 3 = minutes tens
- **Tens/ones split.** Derived from the 6-bit value (≤59) with a compare chain. No divider.
- **Drive.** `an = ~(4'b0001 << idx)`. `seg` is the decode of the selected digit.
- **Decode (hex, active low):** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- **Blink.** When `adj=1`, `clockBlink=1` and `idx` belongs to the selected field, `an` is forced to 4'hF and `seg` to 7'h7F.

## Timing
- **Reset values:**
  - `min_o`=0, `sec_o`=0, `paused`=0
  - `idx`=0
  - `an`=4'hF, `seg`=7'h7F
  - prev registers = 1
- **Tick latency.** Counters and `idx` update on the first clk edge that samples the source input high with prev=0. The new value is visible on `min_o`/`sec_o` one cycle after the input rises.
- **Pause latency.** `paused` updates on the edge that samples `pause_p` high.
- **Display latency.** `an`/`seg` are registered from `idx`, the counters, `adj`, `sel` and `clockBlink`. They lag those signals by one cycle, so a count change reaches `seg` two cycles after the input rises.
- **Tick rate.** Exactly one tick per source rising edge, independent of high-time length.
- **Reset mid-operation.** Reset applied in any mode returns every output to its reset value on the next edge. After release, the first tick requires a low→high transition of the source.

## Structure
- **Shared package `stopwatch_pkg`:**
  - seven-segment digit constants 0–9
  - `SEG_BLANK`=7'h7F, `AN_OFF`=4'hF
  - digit index constants `DIG_SEC_ONES`..`DIG_MIN_TENS`
  - field select constants `SEL_MIN`/`SEL_SEC`
- **Sub-module `seg7_decode`:** combinational 4-bit BCD → 7-bit active-low segments. Codes 10–15 map to `SEG_BLANK`.
- **Top level:** edge detectors, counter/pause logic, scan counter and output registers all live in `stopwatch_core`.

## Test plan
- **Reset, first tick.** Hold `rst` 2 cycles with `clock1Hz`=1, then release → no tick until `clock1Hz` goes 0→1. After that rise `sec_o`=1; `an`=4'hF and `seg`=7'h7F during reset.
- **Run wrap.** Preload by adjust to 59:59, set `adj`=0, send one 1 Hz rise → `min_o`=0 and `sec_o`=0 one cycle later. At 00:59, one rise → 01:00.
- **Pause.** Pulse `pause_p` in the same cycle as a 1 Hz rise at 00:05 → `sec_o`=6 and `paused`=1. Send three more rises → `sec_o` stays 6. Pulse again → the next rise gives 7.
- **Adjust.** `adj`=1, `sel`=0, `min_o`=58, send three 2 Hz rises → `min_o`=59, 0, 1 with `sec_o` unchanged. Send 1 Hz rises → no change.
- **Scan/blink.** Count 12:34, four `clockFast` rises → (`an`, `seg`) = (E,19), (D,30), (B,24), (7,79). With `adj`=1, `sel`=1, `clockBlink`=1 → digits 0 and 1 show `an`=F, `seg`=7F.
